// File: rtl/mdu_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mdu_pkg: shared op codes, FSM states and default width for mult_div_unit.
// Rev 1.0
// ----------------------------------------------------------------------------
package mdu_pkg;

  localparam int MDU_WIDTH = 32;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIN  = 2'd2
  } mdu_state_e;

endpackage
`default_nettype wire

// File: rtl/mult_div_unit_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mult_div_unit_if: operand/control bus between the execute stage and the MDU.
// Rev 1.0
// ----------------------------------------------------------------------------
interface mult_div_unit_if #(
  parameter int WIDTH = mdu_pkg::MDU_WIDTH
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, opA, opB, input busy, done, hi, lo);
  modport slave  (input start, op, opA, opB, output busy, done, hi, lo);
endinterface
`default_nettype wire

// File: rtl/mdu_sign_adjust.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mdu_sign_adjust: conditional two's-complement negate (abs value / sign fix).
// Rev 1.0
// ----------------------------------------------------------------------------
module mdu_sign_adjust #(
  parameter int WIDTH = 32
) (
  input  wire logic             i_neg,
  input  wire logic [WIDTH-1:0] i_val,
  output logic      [WIDTH-1:0] o_val
);
  assign o_val = i_neg ? (~i_val + WIDTH'(1)) : i_val;
endmodule
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mult_div_unit: iterative shift-add multiply / restoring divide with HI/LO.
// Rev 1.0 -- optional MDU_EARLY_TERM_EN ends a multiply once the multiplier is 0.
// ----------------------------------------------------------------------------
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input wire logic        CLK,
  input wire logic        RST,
  mult_div_unit_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  mdu_state_e         r_state, w_state_nxt;
  logic [CW-1:0]      r_cnt;
  logic               r_is_div, r_dz, r_sign_q, r_sign_r, r_done;
  logic [WIDTH-1:0]   r_hi, r_lo, r_opa, r_mplier;
  logic [2*WIDTH-1:0] r_acc, r_mcand;

  logic               w_signed, w_accept, w_move, w_last, w_ge;
  logic [WIDTH-1:0]   w_abs_a, w_abs_b, w_mplier_nxt, w_rem_sub, w_fix_rem;
  logic [WIDTH:0]     w_trial;
  logic [2*WIDTH-1:0] w_div_acc, w_fix_acc;

  assign w_signed = ~bus.op[0];
  assign w_accept = (r_state == ST_IDLE) && bus.start && !bus.op[2];
  assign w_move   = (r_state == ST_IDLE) && bus.start && (bus.op[2:1] == 2'b10);
  assign w_last   = (r_cnt == CW'(WIDTH - 1));

  mdu_sign_adjust #(.WIDTH(WIDTH)) u_abs_a (
    .i_neg(w_signed & bus.opA[WIDTH-1]), .i_val(bus.opA), .o_val(w_abs_a));
  mdu_sign_adjust #(.WIDTH(WIDTH)) u_abs_b (
    .i_neg(w_signed & bus.opB[WIDTH-1]), .i_val(bus.opB), .o_val(w_abs_b));

  // Negating the full {rem,quot} accumulator also yields the negated quotient in its low half.
  mdu_sign_adjust #(.WIDTH(2*WIDTH)) u_fix_acc (
    .i_neg(r_sign_q), .i_val(r_acc), .o_val(w_fix_acc));
  mdu_sign_adjust #(.WIDTH(WIDTH)) u_fix_rem (
    .i_neg(r_sign_r), .i_val(r_acc[2*WIDTH-1:WIDTH]), .o_val(w_fix_rem));

  assign w_mplier_nxt = r_mplier >> 1;

  // Divide keeps {remainder, dividend/quotient} in r_acc; r_mplier holds the divisor.
  assign w_trial   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_ge      = (w_trial >= {1'b0, r_mplier});
  assign w_rem_sub = w_trial[WIDTH-1:0] - r_mplier;
  assign w_div_acc = {(w_ge ? w_rem_sub : w_trial[WIDTH-1:0]), r_acc[WIDTH-2:0], w_ge};

  always_ff @(posedge CLK) begin
    if (RST) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = ST_CALC;
      ST_CALC: begin
        if (w_last) w_state_nxt = ST_FIN;
`ifdef MDU_EARLY_TERM_EN
        else if (!r_is_div && (w_mplier_nxt == '0)) w_state_nxt = ST_FIN;
`endif
      end
      ST_FIN:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_dz     <= 1'b0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_opa    <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_is_div <= bus.op[1];
            r_dz     <= (bus.opB == '0);
            r_sign_q <= w_signed & (bus.opA[WIDTH-1] ^ bus.opB[WIDTH-1]);
            r_sign_r <= w_signed & bus.opA[WIDTH-1];
            r_opa    <= bus.opA;
            r_mplier <= w_abs_b;
            r_cnt    <= '0;
            if (bus.op[1]) begin
              r_acc   <= {{WIDTH{1'b0}}, w_abs_a};
              r_mcand <= '0;
            end else begin
              r_acc   <= '0;
              r_mcand <= {{WIDTH{1'b0}}, w_abs_a};
            end
          end else if (w_move) begin
            if (bus.op[0]) r_lo <= bus.opA;
            else           r_hi <= bus.opA;
            r_done <= 1'b1;
          end
        end
        ST_CALC: begin
          r_cnt <= r_cnt + CW'(1);
          if (r_is_div) begin
            r_acc <= w_div_acc;
          end else begin
            if (r_mplier[0]) r_acc <= r_acc + r_mcand;
            r_mcand  <= r_mcand << 1;
            r_mplier <= w_mplier_nxt;
          end
        end
        ST_FIN: begin
          r_done <= 1'b1;
          if (r_is_div && r_dz) begin
            r_hi <= r_opa;
            r_lo <= '1;
          end else if (r_is_div) begin
            r_hi <= w_fix_rem;
            r_lo <= w_fix_acc[WIDTH-1:0];
          end else begin
            r_hi <= w_fix_acc[2*WIDTH-1:WIDTH];
            r_lo <= w_fix_acc[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (r_state != ST_IDLE);
  assign bus.done = r_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mult_div_unit: scoreboard bench for mult_div_unit (HI/LO values + latency).
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_mult_div_unit;
  import mdu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mult_div_unit_if #(.WIDTH(32)) bus ();
  mult_div_unit #(.WIDTH(32)) dut (.CLK(clk), .RST(rst), .bus(bus));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          at;
    string       nm;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] m_hi    = '0;
  logic [31:0] m_lo    = '0;

  always @(negedge clk) begin : mon
    exp_t e;
    if (bus.done === 1'b1) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_done: cyc=%0d hi=%h lo=%h, required no done pulse", cyc, bus.hi, bus.lo);
      end else begin
        e = sb.pop_front();
        if (bus.hi !== e.hi || bus.lo !== e.lo || cyc !== e.at) begin
          n_fail++;
          $display("FAIL %s: hi=%h lo=%h cyc=%0d, required hi=%h lo=%h cyc=%0d",
                   e.nm, bus.hi, bus.lo, cyc, e.hi, e.lo, e.at);
        end
      end
    end
  end

  // Edges from acceptance to the FIN edge for a multiply with this |multiplier|.
  function automatic int mul_lat(input logic [31:0] mb);
    int hb = 1;
    for (int i = 0; i < 32; i++) if (mb[i]) hb = i + 1;
`ifdef MDU_EARLY_TERM_EN
    return hb + 1;
`else
    return (hb > 0) ? 33 : 33;
`endif
  endfunction

  // Caller is at a negedge; drives a one-cycle start and queues the expected result.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input string nm);
    exp_t        e;
    int          lat;
    int          sa, sbv;
    logic [63:0] p;
    logic [31:0] ab;
    sa  = a;
    sbv = b;
    lat = 33;
    case (op)
      OP_MULT: begin
        p    = longint'(sa) * longint'(sbv);
        ab   = b[31] ? (~b + 32'd1) : b;
        lat  = mul_lat(ab);
        m_hi = p[63:32];
        m_lo = p[31:0];
      end
      OP_MULTU: begin
        p    = {32'd0, a} * {32'd0, b};
        lat  = mul_lat(b);
        m_hi = p[63:32];
        m_lo = p[31:0];
      end
      OP_DIV: begin
        if (b == 32'd0) begin m_hi = a; m_lo = '1; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin m_hi = '0; m_lo = a; end
        else begin m_lo = sa / sbv; m_hi = sa % sbv; end
      end
      OP_DIVU: begin
        if (b == 32'd0) begin m_hi = a; m_lo = '1; end
        else begin m_lo = a / b; m_hi = a % b; end
      end
      OP_MTHI: begin m_hi = a; lat = 0; end
      OP_MTLO: begin m_lo = a; lat = 0; end
      default: lat = -1;
    endcase
    bus.start = 1'b1;
    bus.op    = op;
    bus.opA   = a;
    bus.opB   = b;
    if (lat >= 0) begin
      e.hi = m_hi; e.lo = m_lo; e.at = cyc + 1 + lat; e.nm = nm;
      sb.push_back(e);
    end
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 80 && sb.size() != 0; i++) @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h, required 0 0 0 0", bus.busy, bus.done, bus.hi, bus.lo);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mult();
    issue(OP_MULT, 32'hFFFF_FFFF, 32'h2, "mult_neg");
    n_tests++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mult_busy: busy=%b, required 1", bus.busy);
    end
    wait_drain();
    n_tests++;
    if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFFE) begin
      n_fail++;
      $display("FAIL mult_const: hi=%h lo=%h, required ffffffff fffffffe", bus.hi, bus.lo);
    end
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'h2, "multu");
    wait_drain();
    n_tests++;
    if (bus.hi !== 32'h1 || bus.lo !== 32'hFFFF_FFFE) begin
      n_fail++;
      $display("FAIL multu_const: hi=%h lo=%h, required 00000001 fffffffe", bus.hi, bus.lo);
    end
    for (int i = 0; i < 4; i++) begin
      issue((i % 2 == 0) ? OP_MULT : OP_MULTU, $urandom, $urandom >> (i * 8), "mult_rand");
      wait_drain();
    end
  endtask

  task automatic test_div();
    logic [31:0] b;
    issue(OP_DIV, 32'hFFFF_FFF9, 32'h2, "div_neg");
    wait_drain();
    n_tests++;
    if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFFD) begin
      n_fail++;
      $display("FAIL div_const: hi=%h lo=%h, required ffffffff fffffffd", bus.hi, bus.lo);
    end
    issue(OP_DIVU, 32'd7, 32'd2, "divu");
    wait_drain();
    n_tests++;
    if (bus.hi !== 32'd1 || bus.lo !== 32'd3) begin
      n_fail++;
      $display("FAIL divu_const: hi=%h lo=%h, required 00000001 00000003", bus.hi, bus.lo);
    end
    for (int i = 0; i < 4; i++) begin
      b = $urandom >> (i * 7);
      if (b == 32'd0 || b == 32'hFFFF_FFFF) b = 32'd13;
      issue((i % 2 == 0) ? OP_DIV : OP_DIVU, $urandom, b, "div_rand");
      wait_drain();
    end
  endtask

  task automatic test_div_corner();
    issue(OP_DIVU, 32'd7, 32'd0, "divu_zero");
    wait_drain();
    n_tests++;
    if (bus.hi !== 32'd7 || bus.lo !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL div_by_zero: hi=%h lo=%h, required 00000007 ffffffff", bus.hi, bus.lo);
    end
    issue(OP_DIV, 32'hFFFF_FFF0, 32'd0, "div_zero_signed");
    wait_drain();
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
    wait_drain();
    n_tests++;
    if (bus.hi !== 32'd0 || bus.lo !== 32'h8000_0000) begin
      n_fail++;
      $display("FAIL div_overflow: hi=%h lo=%h, required 00000000 80000000", bus.hi, bus.lo);
    end
  endtask

  task automatic test_move();
    issue(OP_MTHI, 32'h1234_5678, 32'hDEAD_BEEF, "mthi");
    n_tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b1 || bus.hi !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL mthi: busy=%b done=%b hi=%h, required 0 1 12345678", bus.busy, bus.done, bus.hi);
    end
    issue(OP_MTLO, 32'h9ABC_DEF0, 32'd0, "mtlo");
    n_tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b1 || bus.lo !== 32'h9ABC_DEF0 || bus.hi !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL mtlo: busy=%b done=%b hi=%h lo=%h, required 0 1 12345678 9abcdef0",
               bus.busy, bus.done, bus.hi, bus.lo);
    end
    wait_drain();
  endtask

  task automatic test_ignored();
    issue(OP_MULTU, 32'd3, 32'd4, "mult_under_start");
    repeat (4) @(negedge clk);
    bus.start = 1'b1; bus.op = OP_DIVU; bus.opA = 32'd1000; bus.opB = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    wait_drain();
    n_tests++;
    if (bus.hi !== 32'd0 || bus.lo !== 32'd12) begin
      n_fail++;
      $display("FAIL start_while_busy: hi=%h lo=%h, required 00000000 0000000c", bus.hi, bus.lo);
    end
    bus.start = 1'b1; bus.op = 3'b110; bus.opA = 32'h5555_5555; bus.opB = 32'd1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (bus.busy !== 1'b0 || bus.hi !== m_hi || bus.lo !== m_lo) begin
      n_fail++;
      $display("FAIL op_noop: busy=%b hi=%h lo=%h, required 0 %h %h", bus.busy, bus.hi, bus.lo, m_hi, m_lo);
    end
  endtask

  task automatic test_back_to_back();
    int i;
    issue(OP_MULTU, 32'd6, 32'd7, "b2b_first");
    for (i = 0; i < 80 && bus.done !== 1'b1; i++) @(negedge clk);
    n_tests++;
    if (bus.done !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_done_timeout: done=%b, required 1", bus.done);
    end
    issue(OP_DIVU, 32'd100, 32'd9, "b2b_second");
    wait_drain();
    n_tests++;
    if (bus.hi !== 32'd1 || bus.lo !== 32'd11) begin
      n_fail++;
      $display("FAIL b2b_second_value: hi=%h lo=%h, required 00000001 0000000b", bus.hi, bus.lo);
    end
  endtask

  task automatic test_early_term();
    issue(OP_MULTU, 32'd5, 32'd1, "multu_by_one");
    wait_drain();
    n_tests++;
    if (bus.hi !== 32'd0 || bus.lo !== 32'd5) begin
      n_fail++;
      $display("FAIL multu_by_one: hi=%h lo=%h, required 00000000 00000005", bus.hi, bus.lo);
    end
    issue(OP_MULT, 32'hFFFF_FFFD, 32'd0, "mult_by_zero");
    wait_drain();
    issue(OP_MULT, 32'd9, 32'hFFFF_FFFC, "mult_neg_small");
    wait_drain();
  endtask

  task automatic test_reset_mid();
    issue(OP_DIVU, 32'd100, 32'd7, "divu_aborted");
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_mid_op: busy=%b done=%b hi=%h lo=%h, required 0 0 0 0", bus.busy, bus.done, bus.hi, bus.lo);
    end
    rst = 1'b0;
    sb.delete();
    m_hi = '0;
    m_lo = '0;
    repeat (40) @(negedge clk);
    n_tests++;
    if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_mid_after: busy=%b hi=%h lo=%h, required 0 0 0", bus.busy, bus.hi, bus.lo);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.op    = 3'b000;
    bus.opA   = '0;
    bus.opB   = '0;
    test_reset();
    test_mult();
    test_div();
    test_div_corner();
    test_move();
    test_ignored();
    test_back_to_back();
    test_early_term();
    test_reset_mid();
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d results pending, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multicycle multiply/divide unit with private HI/LO registers for the MIPS multicycle CPU.
- Consumes the two register-file read operands (rs value, rt value) in the execute stage.
- Runs an iterative shift-add multiply or restoring divide and exposes HI/LO for MFHI/MFLO.
- The control FSM stalls on busy and proceeds on done.

Parameters:
- WIDTH, 32, operand/HI/LO width; iteration count equals WIDTH.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- op  input  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op.
- opA  input  WIDTH  rs value (multiplicand/dividend/MTHI-MTLO source).
- opB  input  WIDTH  rt value (multiplier/divisor).
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when HI/LO have just been updated.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (RST=1 at a rising edge, overrides everything):
  - state=IDLE; busy=0, done=0, hi=0, lo=0; all internal accumulators cleared.
  - Reset mid-operation aborts it; no done pulse is produced.
- States: IDLE, CALC, FIN. busy=1 exactly in CALC and FIN. done is registered.
- Operation accepted at edge E0 (IDLE, start=1, op MULT..DIVU):
  - Latch |opA|, |opB| for signed ops, raw values for unsigned ops.
  - Latch result signs: product/quotient sign = opA[MSB]^opB[MSB]; remainder sign = opA[MSB]. Both are 0 for unsigned ops.
  - Latch a divide-by-zero flag (opB==0). Set iteration counter=0. Go to CALC.
- CALC: one iteration per edge.
  - Multiply: LSB-first shift-add into a 2*WIDTH accumulator.
  - Divide: restoring step, one quotient bit per edge, MSB first.
  - After the WIDTH-th iteration (E32) go to FIN.
- FIN edge (E33):
  - Apply sign fix (two's-complement negate where the latched sign is 1).
  - Multiply: hi=product[2W-1:W], lo=product[W-1:0].
  - Divide: lo=quotient, hi=remainder.
  - done=1 for the cycle after E33; state=IDLE.
- Latency: done is visible 33 edges after the accepting edge; hi/lo hold the new values from that same cycle onward.
- Divide by zero: still takes full latency; sign fix bypassed; hi=opA as originally presented, lo=all ones.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0. This falls out of the WIDTH-bit wrap.
- MTHI/MTLO in IDLE with start=1: write opA to hi (resp. lo) at E0; done=1 the next cycle; busy stays 0.
- op 11x with start: ignored; no done.
- start while busy: ignored; operands are not re-latched.
- hi/lo are stable except at a FIN edge, an MTHI/MTLO edge, or reset.
- start may be asserted in the cycle done is high; it is accepted, because the state is IDLE.

Optional Feature:
- Macro: MDU_EARLY_TERM_EN.
- Defined:
  - For MULT/MULTU only: at a CALC edge, if the remaining (right-shifted) multiplier is zero after that iteration, the next state is FIN.
  - Minimum latency is 2 edges (opB=0 or |opB|=1: iterate at E1, write at E2).
  - Divide latency is unchanged.
- Undefined: fixed WIDTH+1-edge latency for all multiply/divide ops; no zero-detect logic is built.

Decomposition:
- Package mdu_pkg:
  - op encodings (OP_MULT..OP_MTLO)
  - FSM state encoding
  - default WIDTH constant
- One sub-module is natural: mdu_sign_adjust, a combinational conditional two's-complement negate. It is instantiated for operand abs-value and for result fix-up.
- The FSM and datapath stay in mult_div_unit.

Test Plan:
- MULT opA=0xFFFFFFFF, opB=0x00000002 -> done after E33; hi=0xFFFFFFFF, lo=0xFFFFFFFE. MULTU with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- DIV opA=0xFFFFFFF9 (-7), opB=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU opA=7, opB=2 -> lo=3, hi=1.
- DIVU opA=7, opB=0 -> lo=0xFFFFFFFF, hi=7. DIV opA=0x80000000, opB=0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI opA=0x12345678, then MTLO opA=0x9ABCDEF0 -> each sets done the next cycle with busy=0; a second start during a MULT is ignored and its operands do not affect the result.
- RST asserted at E10 of a DIVU -> next cycle busy=0, done=0, hi=lo=0; no later done pulse.
- With MDU_EARLY_TERM_EN: MULTU opA=5, opB=1 -> done after E2, lo=5, hi=0. Without the macro -> done after E33, same values.
